coin_credit_bank: RTL and testbench
===================================

COIN_CREDIT_BANK -- requirements
Module: coin_credit_bank

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PRICE, 4, credits per game (>=1)
- VAL1, 1, credit for coin code 2'b01
- VAL2, 3, credit for coin code 2'b10
- VAL3, 5, credit for coin code 2'b11
- CREDIT_W, 4, credit register width; CREDIT_MAX = 2**CREDIT_W-1
- MAX_GAMES, 7, bank capacity; GAME_W = $clog2(MAX_GAMES+1)
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, input, 1, sole clock, rising edge
- reset_L, input, 1, asynchronous active-low reset
- coinInserted, input, 1, level, high while a coin is presented
- coinValue, input, 2, coin code; 2'b00 = no coin
- startGame, input, 1, level request to consume one banked game
- credit, output, CREDIT_W, leftover credit below purchase threshold
- numGames, output, GAME_W, banked games
- drop, output, 1, one-cycle pulse per game purchased
- gameGranted, output, 1, one-cycle pulse per game consumed
- coinReject, output, 1, one-cycle pulse when a coin is refused
- busy, output, 1, high in VEND and HOLD

Function
REQ-003 FSM states SHALL be IDLE, VEND and HOLD.
REQ-004 In IDLE with coinInserted=1 and coinValue!=0, the coin SHALL be evaluated: if credit+value <= CREDIT_MAX, credit SHALL become credit+value at the next edge and the state SHALL go to VEND; otherwise coinReject SHALL pulse for one cycle, credit SHALL stay unchanged and the state SHALL go to HOLD.
REQ-005 In IDLE with no coin present, credit >= PRICE and numGames < MAX_GAMES, the state SHALL go to VEND.
REQ-006 VEND, per cycle: if credit >= PRICE and numGames < MAX_GAMES, credit SHALL decrease by PRICE, numGames SHALL increase by 1 and drop SHALL be 1; otherwise the state SHALL exit.
REQ-007 VEND SHALL exit to HOLD if coinInserted=1, else to IDLE.
REQ-008 HOLD SHALL remain until coinInserted=0, then go to IDLE.
REQ-009 A single insertion SHALL be credited exactly once, however long coinInserted stays high.
REQ-010 Coins presented in VEND or HOLD SHALL be ignored: no credit, no reject.
REQ-011 startGame SHALL be rising-edge detected through a registered copy.
REQ-012 On a startGame rising edge with numGames > 0, gameGranted SHALL pulse in the next cycle and numGames SHALL decrement; with numGames = 0 the edge SHALL be dropped silently.
REQ-013 Grants SHALL be honoured in every state.
REQ-014 A grant and a VEND increment in the same cycle SHALL net to zero change in numGames.
REQ-015 numGames SHALL never exceed MAX_GAMES and never underflow.
REQ-016 Credit arithmetic SHALL be CREDIT_W+1 bits wide, so the overflow check is exact.
REQ-017 Excess credit SHALL be held, never discarded, when the bank is full.
REQ-018 Parameter constraints SHALL be checked at elaboration: PRICE and VALn <= CREDIT_MAX; PRICE >= 1.

Reset
REQ-019 reset_L=0 SHALL immediately set state to IDLE, clear credit, numGames, drop, gameGranted, coinReject and busy to 0, and clear the startGame edge register.
REQ-020 Reset asserted mid-VEND SHALL abandon the sequence with no further drop pulses.
REQ-021 Reset SHALL be released synchronously to clock by the instantiating level.

Structure
REQ-022 Package coin_pkg SHALL hold the state enum and the coin-code typedef (COIN_NONE, COIN_1, COIN_2, COIN_3).
REQ-023 Sub-module game_bank SHALL implement the saturating up/down counter with inc, dec and MAX parameters.

Verification
REQ-024 Default parameters, four 3-cycle pulses with coinValue=01: credit 1,2,3, then a single drop pulse, credit=0, numGames=1.
REQ-025 Default parameters, coin 11 twice: first gives numGames=1, credit=1; second gives numGames=2, credit=2 with one drop each.
REQ-026 PRICE=2, one coin 11: two consecutive drop cycles, numGames=2, credit=1.
REQ-027 Bank full (7 games), credit=3, coin 10: credit=6 with no drop. Then a startGame edge: gameGranted pulses, numGames=6, then VEND restores numGames=7 with credit=2.
REQ-028 Bank full, credit=13, coin 11: coinReject pulses, credit stays 13; startGame with numGames=0 produces no gameGranted.
REQ-029 reset_L driven low mid-VEND: all outputs 0 within the same cycle; no drop after release.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types for the coin credit bank: controller states and coin codes.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_2    = 2'b10,
    COIN_3    = 2'b11
  } coin_t;

endpackage

// File: rtl/game_bank.sv
// Saturating up/down counter holding the number of banked games.
module game_bank #(
  parameter int MAX = 7,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         reset_L,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_C = W'(MAX);
  localparam logic [W-1:0] ONE_C = W'(1);

  // Simultaneous inc and dec cancel; each direction saturates at its limit.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else if (inc && !dec && (count < MAX_C)) begin
      count <= count + ONE_C;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - ONE_C;
    end
  end

endmodule

// File: rtl/coin_credit_bank.sv
// Coin acceptor with credit accumulation, game purchase and a banked-game counter.
module coin_credit_bank
  import coin_pkg::*;
#(
  parameter int PRICE     = 4,
  parameter int VAL1      = 1,
  parameter int VAL2      = 3,
  parameter int VAL3      = 5,
  parameter int CREDIT_W  = 4,
  parameter int MAX_GAMES = 7,
  localparam int GAME_W   = $clog2(MAX_GAMES + 1)
) (
  input  logic                clock,
  input  logic                reset_L,
  input  logic                coinInserted,
  input  logic [1:0]          coinValue,
  input  logic                startGame,
  output logic [CREDIT_W-1:0] credit,
  output logic [GAME_W-1:0]   numGames,
  output logic                drop,
  output logic                gameGranted,
  output logic                coinReject,
  output logic                busy
);

  localparam int CREDIT_MAX_I = (1 << CREDIT_W) - 1;

  if ((PRICE < 1) || (PRICE > CREDIT_MAX_I) || (VAL1 > CREDIT_MAX_I) ||
      (VAL2 > CREDIT_MAX_I) || (VAL3 > CREDIT_MAX_I)) begin : g_param_check
    $error("coin_credit_bank: PRICE must be in 1..CREDIT_MAX and each VALn <= CREDIT_MAX");
  end

  // One extra bit so credit + coin value never wraps before the limit test.
  localparam logic [CREDIT_W:0]   CREDIT_MAX_C = (CREDIT_W + 1)'(CREDIT_MAX_I);
  localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   VAL1_C       = (CREDIT_W + 1)'(VAL1);
  localparam logic [CREDIT_W:0]   VAL2_C       = (CREDIT_W + 1)'(VAL2);
  localparam logic [CREDIT_W:0]   VAL3_C       = (CREDIT_W + 1)'(VAL3);
  localparam logic [GAME_W-1:0]   MAX_GAMES_C  = GAME_W'(MAX_GAMES);

  state_t              state;
  state_t              state_n;
  coin_t               coin_code;
  logic [CREDIT_W:0]   coin_amt;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] credit_n;
  logic                coin_present;
  logic                can_vend;
  logic                vend_fire;
  logic                reject_fire;
  logic                start_q;
  logic                grant_fire;

  assign coin_code    = coin_t'(coinValue);
  assign coin_present = coinInserted && (coin_code != COIN_NONE);
  assign credit_sum   = {1'b0, credit} + coin_amt;
  assign can_vend     = (credit >= PRICE_C) && (numGames < MAX_GAMES_C);
  assign grant_fire   = startGame && !start_q && (numGames != '0);
  assign busy         = (state != IDLE);

  // Credit value carried by the presented coin code.
  always_comb begin
    coin_amt = '0;
    case (coin_code)
      COIN_1:  coin_amt = VAL1_C;
      COIN_2:  coin_amt = VAL2_C;
      COIN_3:  coin_amt = VAL3_C;
      default: coin_amt = '0;
    endcase
  end

  // Next-state, credit update and single-cycle event decisions.
  always_comb begin
    state_n     = state;
    credit_n    = credit;
    vend_fire   = 1'b0;
    reject_fire = 1'b0;
    case (state)
      IDLE: begin
        if (coin_present) begin
          if (credit_sum <= CREDIT_MAX_C) begin
            credit_n = credit_sum[CREDIT_W-1:0];
            state_n  = VEND;
          end else begin
            reject_fire = 1'b1;
            state_n     = HOLD;
          end
        end else if (can_vend) begin
          state_n = VEND;
        end
      end
      VEND: begin
        if (can_vend) begin
          vend_fire = 1'b1;
          credit_n  = credit - PRICE_C;
        end else begin
          state_n = coinInserted ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!coinInserted) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, credit and registered output pulses.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      credit      <= '0;
      drop        <= 1'b0;
      gameGranted <= 1'b0;
      coinReject  <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      drop        <= vend_fire;
      gameGranted <= grant_fire;
      coinReject  <= reject_fire;
    end
  end

  // Registered copy of startGame for rising-edge detection.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      start_q <= 1'b0;
    end else begin
      start_q <= startGame;
    end
  end

  game_bank #(
    .MAX (MAX_GAMES),
    .W   (GAME_W)
  ) u_game_bank (
    .clock   (clock),
    .reset_L (reset_L),
    .inc     (vend_fire),
    .dec     (grant_fire),
    .count   (numGames)
  );

endmodule

// File: tb/tb_coin_credit_bank.sv
// Self-checking bench for coin_credit_bank: directed table, corner sequences, random vs. model.
module tb_coin_credit_bank;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       coinInserted = 1'b0;
  logic [1:0] coinValue = 2'b00;
  logic       startGame = 1'b0;
  logic [3:0] credit;
  logic [2:0] numGames;
  logic       drop, gameGranted, coinReject, busy;

  // second instance with PRICE=2
  logic       coin_ins_b = 1'b0;
  logic [1:0] coin_val_b = 2'b00;
  logic       start_b = 1'b0;
  logic [3:0] credit_b;
  logic [2:0] games_b;
  logic       drop_b, granted_b, reject_b, busy_b;

  int checks = 0;
  int failures = 0;
  int drop_cnt = 0, grant_cnt = 0, reject_cnt = 0;

  coin_credit_bank dut (
    .clock(clock), .reset_L(reset_L), .coinInserted(coinInserted), .coinValue(coinValue),
    .startGame(startGame), .credit(credit), .numGames(numGames), .drop(drop),
    .gameGranted(gameGranted), .coinReject(coinReject), .busy(busy)
  );

  coin_credit_bank #(.PRICE(2)) dut_p2 (
    .clock(clock), .reset_L(reset_L), .coinInserted(coin_ins_b), .coinValue(coin_val_b),
    .startGame(start_b), .credit(credit_b), .numGames(games_b), .drop(drop_b),
    .gameGranted(granted_b), .coinReject(reject_b), .busy(busy_b)
  );

  always #5 clock = ~clock;

  // pulse counters, sampled on the falling edge
  always @(negedge clock) begin
    if (drop) drop_cnt++;
    if (gameGranted) grant_cnt++;
    if (coinReject) reject_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    coinInserted = 1'b0; coinValue = 2'b00; startGame = 1'b0;
    reset_L = 1'b0;
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
  endtask

  task automatic coin_txn(input int v, input int len, input bit scramble);
    coinInserted = 1'b1;
    coinValue = 2'(v);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      if (scramble && v != 0) coinValue = 2'($urandom_range(0, 3));
    end
    coinInserted = 1'b0;
    coinValue = 2'b00;
    repeat (10) @(negedge clock);
  endtask

  task automatic grant_txn(input int len);
    startGame = 1'b1;
    repeat (len) @(negedge clock);
    startGame = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_credit, m_games, e_drops, e_grants, e_rejects;

  function automatic int coin_worth(input int v);
    case (v)
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  // Buy as many games as credit and free bank slots allow.
  task automatic model_settle();
    int n;
    n = m_credit / 4;
    if (n > 7 - m_games) n = 7 - m_games;
    m_games += n;
    m_credit -= n * 4;
    e_drops += n;
  endtask

  task automatic model_coin(input int v);
    if (v == 0) return;
    if (m_credit + coin_worth(v) > 15) e_rejects++;
    else begin
      m_credit += coin_worth(v);
      model_settle();
    end
  endtask

  task automatic model_grant();
    if (m_games > 0) begin
      m_games--;
      e_grants++;
      model_settle();
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; int op; int v; int len;
    int c; int g; int d; int rj; int gr;
  } row_t;

  row_t rows[20];

  task automatic run_rows(input int lo, input int hi);
    int d0, g0, r0;
    for (int i = lo; i <= hi; i++) begin
      if (rows[i].rst) do_reset();
      d0 = drop_cnt; g0 = grant_cnt; r0 = reject_cnt;
      if (rows[i].op == 0) coin_txn(rows[i].v, rows[i].len, 1'b0);
      else grant_txn(rows[i].len);
      check($sformatf("row%0d credit", i), int'(credit), rows[i].c);
      check($sformatf("row%0d numGames", i), int'(numGames), rows[i].g);
      check($sformatf("row%0d drops", i), drop_cnt - d0, rows[i].d);
      check($sformatf("row%0d rejects", i), reject_cnt - r0, rows[i].rj);
      check($sformatf("row%0d grants", i), grant_cnt - g0, rows[i].gr);
    end
  endtask

  initial begin
    int d0, g0, r0, op, v, len;
    //          rst op v len  c  g  d rj gr
    rows[0]  = '{1, 0, 1, 3,  1, 0, 0, 0, 0};
    rows[1]  = '{0, 0, 1, 3,  2, 0, 0, 0, 0};
    rows[2]  = '{0, 0, 1, 3,  3, 0, 0, 0, 0};
    rows[3]  = '{0, 0, 1, 3,  0, 1, 1, 0, 0};
    rows[4]  = '{1, 0, 3, 2,  1, 1, 1, 0, 0};
    rows[5]  = '{0, 0, 3, 2,  2, 2, 1, 0, 0};
    rows[6]  = '{0, 0, 3, 1,  3, 3, 1, 0, 0};
    rows[7]  = '{0, 0, 3, 1,  0, 5, 2, 0, 0};
    rows[8]  = '{0, 0, 3, 1,  1, 6, 1, 0, 0};
    rows[9]  = '{0, 0, 3, 1,  2, 7, 1, 0, 0};
    rows[10] = '{0, 0, 1, 1,  3, 7, 0, 0, 0};
    rows[11] = '{0, 0, 2, 3,  6, 7, 0, 0, 0};
    rows[12] = '{0, 0, 3, 1,  7, 7, 0, 0, 0};
    rows[13] = '{0, 0, 3, 1, 12, 7, 0, 0, 0};
    rows[14] = '{0, 0, 1, 1, 13, 7, 0, 0, 0};
    rows[15] = '{0, 0, 3, 3, 13, 7, 0, 1, 0};
    rows[16] = '{1, 1, 0, 1,  0, 0, 0, 0, 0};
    rows[17] = '{0, 0, 1, 9,  1, 0, 0, 0, 0};
    rows[18] = '{0, 0, 0, 3,  1, 0, 0, 0, 0};
    rows[19] = '{0, 1, 0, 2,  1, 0, 0, 0, 0};

    // reset state
    repeat (2) @(negedge clock);
    check("reset credit", int'(credit), 0);
    check("reset numGames", int'(numGames), 0);
    check("reset drop", int'(drop), 0);
    check("reset gameGranted", int'(gameGranted), 0);
    check("reset coinReject", int'(coinReject), 0);
    check("reset busy", int'(busy), 0);
    reset_L = 1'b1;
    @(negedge clock);

    // PRICE=2: one coin 11 gives two back-to-back drops
    coin_ins_b = 1'b1; coin_val_b = 2'b11;
    @(negedge clock);
    coin_ins_b = 1'b0; coin_val_b = 2'b00;
    check("p2 accepted credit", int'(credit_b), 5);
    check("p2 no drop yet", int'(drop_b), 0);
    @(negedge clock);
    check("p2 first drop", int'(drop_b), 1);
    @(negedge clock);
    check("p2 second drop", int'(drop_b), 1);
    check("p2 credit", int'(credit_b), 1);
    check("p2 numGames", int'(games_b), 2);
    @(negedge clock);
    check("p2 drops end", int'(drop_b), 0);

    run_rows(0, 11);

    // full bank, credit 6: grant then refill via VEND
    startGame = 1'b1;
    @(negedge clock);
    check("full grant pulse", int'(gameGranted), 1);
    check("full grant numGames", int'(numGames), 6);
    startGame = 1'b0;
    @(negedge clock);
    check("grant single pulse", int'(gameGranted), 0);
    check("refill busy", int'(busy), 1);
    @(negedge clock);
    check("refill drop", int'(drop), 1);
    check("refill credit", int'(credit), 2);
    check("refill numGames", int'(numGames), 7);
    repeat (8) @(negedge clock);
    check("refill single drop", int'(drop), 0);

    run_rows(12, 19);

    // reset in the middle of a two-game vend sequence
    do_reset();
    coin_txn(2, 1, 1'b0);
    coinInserted = 1'b1; coinValue = 2'b11;
    @(negedge clock);
    coinInserted = 1'b0; coinValue = 2'b00;
    @(negedge clock);
    check("midvend drop before reset", int'(drop), 1);
    #1 reset_L = 1'b0;
    #1;
    check("midvend reset credit", int'(credit), 0);
    check("midvend reset numGames", int'(numGames), 0);
    check("midvend reset drop", int'(drop), 0);
    check("midvend reset busy", int'(busy), 0);
    check("midvend reset gameGranted", int'(gameGranted), 0);
    check("midvend reset coinReject", int'(coinReject), 0);
    d0 = drop_cnt;
    @(negedge clock);
    reset_L = 1'b1;
    repeat (10) @(negedge clock);
    check("midvend no drop after release", drop_cnt - d0, 0);
    check("midvend credit after release", int'(credit), 0);

    // randomized transactions against the model
    do_reset();
    m_credit = 0; m_games = 0; e_drops = 0; e_grants = 0; e_rejects = 0;
    d0 = drop_cnt; g0 = grant_cnt; r0 = reject_cnt;
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 3);
      len = $urandom_range(1, 4);
      if (op < 3) begin
        v = $urandom_range(0, 3);
        coin_txn(v, len, 1'b1);
        model_coin(v);
      end else begin
        grant_txn(len);
        model_grant();
      end
      check($sformatf("rand%0d credit", t), int'(credit), m_credit);
      check($sformatf("rand%0d numGames", t), int'(numGames), m_games);
      check($sformatf("rand%0d drops", t), drop_cnt - d0, e_drops);
      check($sformatf("rand%0d grants", t), grant_cnt - g0, e_grants);
      check($sformatf("rand%0d rejects", t), reject_cnt - r0, e_rejects);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
